// File: rtl/operand_entry_fsm.sv
// operand_entry_fsm: builds hex operands from keypad strobes and emits new_input/finish_input pulses
module operand_entry_fsm #(
  parameter int DIGITS      = 3,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  digit_valid,
  input  logic [3:0]            digit,
  input  logic                  enter_pulse,
  input  logic                  clear_pulse,
  input  logic                  finish_pulse,
  output logic [4*DIGITS-1:0]   num1_hex,
  output logic [4*DIGITS-1:0]   num2_hex,
  output logic                  new_input,
  output logic                  finish_input,
  output logic [4*DIGITS-1:0]   entry_hex,
  output logic [1:0]            entry_sel
);
  localparam int NW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  typedef enum logic [1:0] {S_NUM1, S_NUM2, S_BUSY, S_ACC} state_t;
  state_t        state_q, state_d;
  logic [NW-1:0] num1_q, num1_d, num2_q, num2_d, cur, shifted;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    hold_q, hold_d;
  logic          new_q, new_d, fin_q, fin_d, full, has;
  assign cur     = (state_q == S_NUM1) ? num1_q : num2_q;
  assign shifted = {cur[NW-5:0], digit};
  assign full    = cnt_q == CW'(DIGITS);
  assign has     = cnt_q != '0;
  always_comb begin
    state_d = state_q;
    num1_d  = num1_q;
    num2_d  = num2_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    new_d   = 1'b0;
    fin_d   = 1'b0;
    case (state_q)
      S_NUM1: begin
        if (finish_pulse) begin
        end else if (clear_pulse) begin
          num1_d = '0;
          cnt_d  = '0;
        end else if (enter_pulse) begin
          state_d = has ? S_NUM2 : S_NUM1;
          cnt_d   = has ? '0 : cnt_q;
        end else if (digit_valid && !full) begin
          num1_d = shifted;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      S_BUSY: begin
        hold_d  = hold_q - 4'd1;
        state_d = (hold_q == 4'd1) ? S_ACC : S_BUSY;
        cnt_d   = '0;
      end
      default: begin
        if (finish_pulse) begin
          if (state_q == S_ACC) begin
            fin_d   = 1'b1;
            num1_d  = '0;
            num2_d  = '0;
            cnt_d   = '0;
            state_d = S_NUM1;
          end
        end else if (clear_pulse) begin
          num2_d = '0;
          cnt_d  = '0;
        end else if (enter_pulse) begin
          if (has) begin
            new_d   = 1'b1;
            hold_d  = 4'(HOLD_CYCLES);
            state_d = S_BUSY;
          end
        end else if (digit_valid && !full) begin
          // the first ACC digit replaces the held sum instead of shifting into it
          num2_d = (state_q == S_ACC && !has) ? {{(NW-4){1'b0}}, digit} : shifted;
          cnt_d  = cnt_q + 1'b1;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_NUM1;
      num1_q  <= '0;
      num2_q  <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      new_q   <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      new_q   <= new_d;
      fin_q   <= fin_d;
    end
  end
  assign num1_hex     = num1_q;
  assign num2_hex     = num2_q;
  assign new_input    = new_q;
  assign finish_input = fin_q;
  assign entry_hex    = cur;
  assign entry_sel    = state_q;
endmodule

// File: tb/tb_operand_entry_fsm.sv
// tb_operand_entry_fsm: directed and random keypad traffic checked against an abstract entry model
module tb_operand_entry_fsm;
  localparam int DIGITS = 3;
  localparam int HOLD   = 2;
  logic        clk = 0, rst = 0;
  logic        digit_valid = 0, enter_pulse = 0, clear_pulse = 0, finish_pulse = 0;
  logic [3:0]  digit = 0;
  logic [11:0] num1_hex, num2_hex, entry_hex;
  logic        new_input, finish_input;
  logic [1:0]  entry_sel;
  int errors = 0, checks = 0;
  int m_mode, m_n1, m_n2, m_cnt, m_left, m_new, m_fin;
  always #5 clk = ~clk;
  operand_entry_fsm #(.DIGITS(DIGITS), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
    .enter_pulse(enter_pulse), .clear_pulse(clear_pulse), .finish_pulse(finish_pulse),
    .num1_hex(num1_hex), .num2_hex(num2_hex), .new_input(new_input),
    .finish_input(finish_input), .entry_hex(entry_hex), .entry_sel(entry_sel)
  );
  task automatic check(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    check("num1", num1_hex, m_n1);
    check("num2", num2_hex, m_n2);
    check("new_input", new_input, m_new);
    check("finish_input", finish_input, m_fin);
    check("entry_sel", entry_sel, m_mode);
    check("entry_hex", entry_hex, m_mode == 0 ? m_n1 : m_n2);
  endtask
  // mode: 0 NUM1, 1 NUM2, 2 BUSY, 3 ACC; m_left = BUSY cycles still to spend
  task automatic model(bit dv, int d, bit en, bit cl, bit fi);
    m_new = 0;
    m_fin = 0;
    if (m_mode == 2) begin
      m_left--;
      if (m_left == 0) begin m_mode = 3; m_cnt = 0; end
    end else if (fi) begin
      if (m_mode == 3) begin m_fin = 1; m_n1 = 0; m_n2 = 0; m_cnt = 0; m_mode = 0; end
    end else if (cl) begin
      if (m_mode == 0) m_n1 = 0; else m_n2 = 0;
      m_cnt = 0;
    end else if (en) begin
      if (m_cnt > 0) begin
        if (m_mode == 0) begin m_mode = 1; m_cnt = 0; end
        else begin m_new = 1; m_left = HOLD; m_mode = 2; end
      end
    end else if (dv && m_cnt < DIGITS) begin
      if (m_mode == 0) m_n1 = (m_n1 * 16 + d) % 4096;
      else if (m_mode == 3 && m_cnt == 0) m_n2 = d;
      else m_n2 = (m_n2 * 16 + d) % 4096;
      m_cnt++;
    end
  endtask
  task automatic step(bit dv, int d, bit en, bit cl, bit fi);
    digit_valid = dv; digit = 4'(d); enter_pulse = en; clear_pulse = cl; finish_pulse = fi;
    @(posedge clk);
    model(dv, d, en, cl, fi);
    #1;
    digit_valid = 0; enter_pulse = 0; clear_pulse = 0; finish_pulse = 0;
    check_all();
  endtask
  task automatic key(int d);  step(1, d, 0, 0, 0); endtask
  task automatic enter();     step(0, 0, 1, 0, 0); endtask
  task automatic idle();      step(0, 0, 0, 0, 0); endtask
  task automatic do_reset();
    rst = 0;
    #1;
    m_mode = 0; m_n1 = 0; m_n2 = 0; m_cnt = 0; m_left = 0; m_new = 0; m_fin = 0;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1;
  endtask
  initial begin
    do_reset();
    idle();
    key(1); key(2); key(3); enter();
    key(4); key(5); key(6); enter();
    check("t1 num1", num1_hex, 'h123);
    check("t1 num2", num2_hex, 'h456);
    check("t1 pulse", new_input, 1);
    check("t1 busy", entry_sel, 2);
    idle();
    check("t1 busy2", entry_sel, 2);
    idle();
    check("t1 acc", entry_sel, 3);
    key(7);
    check("t3 load", num2_hex, 'h007);
    enter();
    check("t3 pulse", new_input, 1);
    idle(); idle();
    step(0, 0, 0, 0, 1);
    check("t3 finish", finish_input, 1);
    check("t3 num1", num1_hex, 0);
    check("t3 sel", entry_sel, 0);
    key('hA); key('hB); key('hC); key('hD);
    check("t2 num1", num1_hex, 'hABC);
    step(0, 0, 0, 1, 0);
    check("t2 clear", num1_hex, 0);
    check("t2 sel", entry_sel, 0);
    key(1); enter(); key(2); enter();
    step(1, 'hF, 0, 0, 0);
    step(0, 0, 1, 0, 1);
    check("t5 num1", num1_hex, 'h001);
    check("t5 num2", num2_hex, 'h002);
    check("t5 fin", finish_input, 0);
    step(1, 9, 1, 0, 1);
    check("t4 fin", finish_input, 1);
    check("t4 new", new_input, 0);
    check("t4 num2", num2_hex, 0);
    enter();
    check("t6 num1 sel", entry_sel, 0);
    key(5); enter(); enter();
    check("t6 num2 sel", entry_sel, 1);
    check("t6 num2 new", new_input, 0);
    key(6); enter(); idle(); idle(); enter();
    check("t6 acc sel", entry_sel, 3);
    check("t6 acc new", new_input, 0);
    key(1); enter();
    do_reset();
    check("t6 rst new", new_input, 0);
    idle();
    check("t6 post new", new_input, 0);
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r == 0 && $urandom_range(0, 4) == 0) do_reset();
      else if (r < 50) key($urandom_range(0, 15));
      else if (r < 72) enter();
      else if (r < 77) step(0, 0, 0, 1, 0);
      else if (r < 87) step(0, 0, 0, 0, 1);
      else if (r < 92) step(1, $urandom_range(0, 15), 1, $urandom_range(0, 1), 1);
      else idle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
